// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-side arbiter.
package fifo_arb_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_W    = 128;
  localparam int DEF_MAX_BURST = 4;
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: first set request at or above i_start, wrapping.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDXW-1:0]    i_start,
  output logic               o_found,
  output logic [IDXW-1:0]    o_idx
);

  always_comb begin : search
    int k;
    k       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(i_start) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!o_found && i_req[IDXW'(k)]) begin
        o_found = 1'b1;
        o_idx   = IDXW'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready
// requesters, with bounded bursts and zero-bubble handover between grants.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_enable,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_fifo_full,
  input  logic                      i_fifo_alm_full,
  output logic                      o_fifo_wren,
  output logic [DATA_W-1:0]         o_fifo_wrdata,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_busy
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCW  = $clog2(MAX_BURST + 1);

  arb_state_e        r_state;
  logic [IDXW-1:0]   r_g;
  logic [IDXW-1:0]   r_ptr;
  logic [BCW-1:0]    r_bcnt;
  logic [NUM_REQ-1:0] r_grant;

  logic              w_busy;
  logic              w_vld_g;
  logic              w_beat;
  logic              w_last;
  logic              w_release;
  logic [IDXW-1:0]   w_g_next;
  logic [IDXW-1:0]   w_start;
  logic              w_found;
  logic [IDXW-1:0]   w_win;

  function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] idx);
    return (idx == IDXW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDXW-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  assign w_busy    = (r_state == GRANT);
  assign w_vld_g   = i_req_valid[r_g];
  assign w_beat    = w_busy & w_vld_g & ~i_fifo_full;
  assign w_last    = ((r_bcnt + BCW'(1)) == BCW'(MAX_BURST));
  // Almost-full shrinks every burst to a single beat; a dropped valid forfeits the grant.
  assign w_release = w_busy & ((w_beat & (w_last | i_fifo_alm_full)) | ~w_vld_g);
  assign w_g_next  = wrap_inc(r_g);
  assign w_start   = w_busy ? w_g_next : r_ptr;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req   (i_req_valid),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_g     <= '0;
      r_ptr   <= '0;
      r_bcnt  <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_enable && w_found) begin
            r_g     <= w_win;
            r_grant <= onehot(w_win);
            r_bcnt  <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_beat) r_bcnt <= r_bcnt + BCW'(1);
          if (w_release) begin
            r_ptr  <= w_g_next;
            r_bcnt <= '0;
            if (i_enable && w_found) begin
              r_g     <= w_win;
              r_grant <= onehot(w_win);
            end else begin
              r_grant <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy        = w_busy;
  assign o_grant       = r_grant;
  assign o_req_ready   = w_beat ? r_grant : '0;
  assign o_fifo_wren   = w_beat;
  assign o_fifo_wrdata = w_busy ? i_req_data[int'(r_g)*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle model comparison plus literal beat logs.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int MB = 4;

  typedef struct {
    int             req;
    logic [DW-1:0]  data;
    int             cyc;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_enable;
  logic [N-1:0]    i_req_valid;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]    o_req_ready;
  logic            i_fifo_full;
  logic            i_fifo_alm_full;
  logic            o_fifo_wren;
  logic [DW-1:0]   o_fifo_wrdata;
  logic [N-1:0]    o_grant;
  logic            o_busy;

  logic [DW-1:0] rq [N][$];
  beat_t log_q[$];
  beat_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_enable        (i_enable),
    .i_req_valid     (i_req_valid),
    .i_req_data      (i_req_data),
    .o_req_ready     (o_req_ready),
    .i_fifo_full     (i_fifo_full),
    .i_fifo_alm_full (i_fifo_alm_full),
    .o_fifo_wren     (o_fifo_wren),
    .o_fifo_wrdata   (o_fifo_wrdata),
    .o_grant         (o_grant),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int m_pick(input int start);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (start + i) % N;
      if (i_req_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      i_req_valid[k]           = (rq[k].size() > 0);
      i_req_data[k*DW +: DW]   = (rq[k].size() > 0) ? rq[k][0] : '0;
    end
  endtask

  // One clock cycle: drive requesters, compare at negedge, advance the model.
  task automatic step();
    logic [N-1:0]  e_grant, e_ready;
    logic [DW-1:0] e_data;
    logic          e_busy, e_wren, rel;
    int            w;
    drive();
    @(negedge clk);
    e_busy  = (m_owner >= 0);
    e_grant = e_busy ? N'(1 << m_owner) : '0;
    e_wren  = e_busy && i_req_valid[m_owner] && !i_fifo_full;
    e_ready = e_wren ? e_grant : '0;
    e_data  = e_busy ? i_req_data[m_owner*DW +: DW] : '0;
    chk("grant",  DW'(o_grant),     DW'(e_grant));
    chk("busy",   DW'(o_busy),      DW'(e_busy));
    chk("wren",   DW'(o_fifo_wren), DW'(e_wren));
    chk("ready",  DW'(o_req_ready), DW'(e_ready));
    chk("wrdata", o_fifo_wrdata,    e_data);
    rel = e_busy && ((e_wren && ((m_cnt + 1 == MB) || i_fifo_alm_full)) || !i_req_valid[m_owner]);
    if (e_wren) begin
      log_q.push_back('{m_owner, e_data, cyc});
      void'(rq[m_owner].pop_front());
      m_cnt++;
    end
    if (!e_busy) begin
      w = m_pick(m_ptr);
      if (i_enable && w >= 0) begin
        m_owner = w;
        m_cnt   = 0;
      end
    end else if (rel) begin
      m_ptr = (m_owner + 1) % N;
      w     = m_pick((m_owner + 1) % N);
      m_owner = (i_enable && w >= 0) ? w : -1;
      m_cnt   = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    cyc     = 0;
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    for (int k = 0; k < N; k++) rq[k].delete();
    drive();
    i_enable = 1'b1; i_fifo_full = 1'b0; i_fifo_alm_full = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_grant",  DW'(o_grant),     '0);
    chk("rst_busy",   DW'(o_busy),      '0);
    chk("rst_wren",   DW'(o_fifo_wren), '0);
    chk("rst_ready",  DW'(o_req_ready), '0);
    chk("rst_wrdata", o_fifo_wrdata,    '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, DW'(log_q.size()), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({name, "_req"},  DW'(log_q[i].req), DW'(exp_q[i].req));
      chk({name, "_data"}, log_q[i].data,     exp_q[i].data);
      chk({name, "_cyc"},  DW'(log_q[i].cyc), DW'(exp_q[i].cyc));
    end
  endtask

  initial begin
    reset = 1'b1; i_enable = 1'b0; i_fifo_full = 1'b0; i_fifo_alm_full = 1'b0;
    i_req_valid = '0; i_req_data = '0;
    @(posedge clk);
    #1;

    // Single requester: 6 beats, re-grant by wrap-around after the 4th.
    do_reset();
    for (int n = 1; n <= 6; n++) rq[0].push_back(DW'(n));
    for (int c = 0; c < 9; c++) step();
    for (int n = 1; n <= 6; n++) exp_q.push_back('{0, DW'(n), n});
    check_log("single");

    // Two continuously valid requesters alternate in blocks of MB.
    do_reset();
    for (int n = 0; n < 8; n++) begin
      rq[0].push_back(DW'(16'h0000 + n));
      rq[1].push_back(DW'(16'h0100 + n));
    end
    for (int c = 0; c < 19; c++) step();
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{(i / 4) % 2, DW'(((i / 4) % 2) * 256 + (i / 8) * 4 + (i % 4)), i + 1});
    check_log("alternate");

    // Full stall for cycles 3..5 after two beats.
    do_reset();
    for (int n = 1; n <= 4; n++) rq[0].push_back(DW'(8'h30 + n));
    for (int c = 0; c < 10; c++) begin
      i_fifo_full = (c >= 3 && c <= 5);
      step();
    end
    i_fifo_full = 1'b0;
    exp_q.push_back('{0, DW'(8'h31), 1});
    exp_q.push_back('{0, DW'(8'h32), 2});
    exp_q.push_back('{0, DW'(8'h33), 6});
    exp_q.push_back('{0, DW'(8'h34), 7});
    check_log("full_stall");

    // Almost-full: one beat per grant, order 0,1,2,3,0.
    do_reset();
    i_fifo_alm_full = 1'b1;
    rq[0].push_back(DW'(12'h001)); rq[0].push_back(DW'(12'h002));
    rq[1].push_back(DW'(12'h101));
    rq[2].push_back(DW'(12'h201));
    rq[3].push_back(DW'(12'h301));
    for (int c = 0; c < 8; c++) step();
    i_fifo_alm_full = 1'b0;
    exp_q.push_back('{0, DW'(12'h001), 1});
    exp_q.push_back('{1, DW'(12'h101), 2});
    exp_q.push_back('{2, DW'(12'h201), 3});
    exp_q.push_back('{3, DW'(12'h301), 4});
    exp_q.push_back('{0, DW'(12'h002), 5});
    check_log("alm_full");

    // Valid drop: req1 leaves after one beat, req2 takes over.
    do_reset();
    rq[1].push_back(DW'(12'h101));
    rq[2].push_back(DW'(12'h201)); rq[2].push_back(DW'(12'h202));
    for (int c = 0; c < 7; c++) step();
    exp_q.push_back('{1, DW'(12'h101), 1});
    exp_q.push_back('{2, DW'(12'h201), 3});
    exp_q.push_back('{2, DW'(12'h202), 4});
    check_log("valid_drop");

    // Asynchronous reset in the middle of a burst.
    do_reset();
    for (int n = 1; n <= 4; n++) rq[0].push_back(DW'(8'h60 + n));
    rq[2].push_back(DW'(8'h71));
    step();
    step();
    drive();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_wren",   DW'(o_fifo_wren), '0);
    chk("arst_grant",  DW'(o_grant),     '0);
    chk("arst_busy",   DW'(o_busy),      '0);
    chk("arst_ready",  DW'(o_req_ready), '0);
    chk("arst_wrdata", o_fifo_wrdata,    '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 8; c++) step();
    exp_q.push_back('{0, DW'(8'h62), 1});
    exp_q.push_back('{0, DW'(8'h63), 2});
    exp_q.push_back('{0, DW'(8'h64), 3});
    exp_q.push_back('{2, DW'(8'h71), 5});
    check_log("async_rst");

    // Enable low holds off new grants until it rises.
    do_reset();
    i_enable = 1'b0;
    rq[3].push_back(DW'(12'h301)); rq[3].push_back(DW'(12'h302));
    for (int c = 0; c < 8; c++) begin
      i_enable = (c >= 3);
      step();
    end
    exp_q.push_back('{3, DW'(12'h301), 4});
    exp_q.push_back('{3, DW'(12'h302), 5});
    check_log("enable");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
